io_uart_fifo: RTL and testbench

//  Parametrised UART register block on the IO bus with TX and RX byte FIFOs.
//  CPU stores to TXDATA queue bytes; the block drains them to the UART TX core.

---
 rtl/io_uart_fifo.sv | 198 +++++++++++++++++++
 tb/tb_io_uart_fifo.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_uart_fifo.sv
// io_uart_fifo: UART register block on the IO bus. CPU bytes written to TXDATA
// are queued and drained to the UART TX core. Bytes from the RX path are queued
// while the CPU runs and popped through RXDATA. STATUS/CTRL expose the FIFO
// levels, sticky overrun flags and flush controls.
module io_uart_fifo #(
    parameter int          TX_DEPTH_LOG2 = 4,
    parameter int          RX_DEPTH_LOG2 = 4,
    parameter logic [13:0] BASE_ADR      = 14'h3F00,
    parameter logic [15:0] TERM_RESET    = 16'd109
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dma_io_we,
    input  logic [13:0] dma_io_wadr,
    input  logic [31:0] dma_io_wdata,
    input  logic        dma_io_radr_en,
    input  logic [13:0] dma_io_radr,
    input  logic [31:0] dma_io_rdata_in,
    output logic [31:0] dma_io_rdata,
    output logic [7:0]  uart_io_char,
    output logic        uart_io_we,
    input  logic        uart_io_full,
    output logic [15:0] uart_term,
    input  logic        cpu_run_state,
    input  logic        rout_en,
    input  logic [7:0]  rout
);

    localparam int TXD = 1 << TX_DEPTH_LOG2;
    localparam int RXD = 1 << RX_DEPTH_LOG2;

    localparam logic [13:0] A_TXDATA = BASE_ADR;
    localparam logic [13:0] A_STATUS = BASE_ADR + 14'd1;
    localparam logic [13:0] A_TERM   = BASE_ADR + 14'd2;
    localparam logic [13:0] A_RXDATA = BASE_ADR + 14'd3;
    localparam logic [13:0] A_CTRL   = BASE_ADR + 14'd4;

    localparam logic [TX_DEPTH_LOG2:0]   TX_FULL_CNT = (TX_DEPTH_LOG2 + 1)'(TXD);
    localparam logic [RX_DEPTH_LOG2:0]   RX_FULL_CNT = (RX_DEPTH_LOG2 + 1)'(RXD);
    localparam logic [TX_DEPTH_LOG2:0]   TX_CNT_ONE  = 1;
    localparam logic [RX_DEPTH_LOG2:0]   RX_CNT_ONE  = 1;
    localparam logic [TX_DEPTH_LOG2-1:0] TX_PTR_ONE  = 1;
    localparam logic [RX_DEPTH_LOG2-1:0] RX_PTR_ONE  = 1;

    // storage and state
    logic [7:0]               tx_mem_q [0:TXD-1];
    logic [7:0]               rx_mem_q [0:RXD-1];
    logic [TX_DEPTH_LOG2-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [RX_DEPTH_LOG2-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [TX_DEPTH_LOG2:0]   tx_cnt_q, tx_cnt_d;
    logic [RX_DEPTH_LOG2:0]   rx_cnt_q, rx_cnt_d;
    logic                     tx_ovr_q, tx_ovr_d, rx_ovr_q, rx_ovr_d;
    logic                     uart_we_q, uart_we_d;
    logic [7:0]               uart_char_q, uart_char_d;
    logic [7:0]               last_tx_q, last_tx_d;
    logic [15:0]              term_q, term_d;
    logic                     rd_hit_q, rd_hit_d;
    logic [31:0]              rd_data_q, rd_data_d;

    // decoded strobes
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic wr_tx, wr_term, wr_ctrl, ctrl_clr, tx_flush, rx_flush;
    logic tx_push, tx_pop, tx_ovr_set;
    logic rx_req, rx_pop, rx_push, rx_ovr_set;
    logic [7:0]  tx_cnt8, rx_cnt8;
    logic [31:0] status_w;

    // only the low half of the write data is ever used
    logic unused_wdata;
    assign unused_wdata = ^dma_io_wdata[31:16];

    assign tx_full  = (tx_cnt_q == TX_FULL_CNT);
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == RX_FULL_CNT);
    assign rx_empty = (rx_cnt_q == '0);
    assign tx_cnt8  = 8'(tx_cnt_q);
    assign rx_cnt8  = 8'(rx_cnt_q);
    assign status_w = {8'd0, rx_cnt8, tx_cnt8, 2'b00, rx_ovr_q, tx_ovr_q,
                       rx_empty, rx_full, tx_empty, tx_full};

    // push/pop/flush decisions; flush overrides any same-cycle push or pop
    always_comb begin
        wr_tx      = dma_io_we && (dma_io_wadr == A_TXDATA);
        wr_term    = dma_io_we && (dma_io_wadr == A_TERM);
        wr_ctrl    = dma_io_we && (dma_io_wadr == A_CTRL);
        ctrl_clr   = wr_ctrl && dma_io_wdata[0];
        tx_flush   = wr_ctrl && dma_io_wdata[1];
        rx_flush   = wr_ctrl && dma_io_wdata[2];
        // the idle cycle after each pulse gives uart_io_full time to react
        tx_pop     = !tx_empty && !uart_io_full && !uart_we_q && !tx_flush;
        tx_push    = wr_tx && !tx_full && !tx_flush;
        tx_ovr_set = wr_tx && tx_full && !tx_flush;
        rx_req     = cpu_run_state && rout_en;
        rx_pop     = dma_io_radr_en && (dma_io_radr == A_RXDATA) && !rx_empty && !rx_flush;
        rx_push    = rx_req && (!rx_full || rx_pop) && !rx_flush;
        rx_ovr_set = rx_req && rx_full && !rx_pop && !rx_flush;
    end

    // next state for both FIFOs, the TX output stage and the sticky flags
    always_comb begin
        tx_wp_d  = tx_push ? tx_wp_q + TX_PTR_ONE : tx_wp_q;
        tx_rp_d  = tx_pop  ? tx_rp_q + TX_PTR_ONE : tx_rp_q;
        tx_cnt_d = tx_cnt_q;
        if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + TX_CNT_ONE;
        if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - TX_CNT_ONE;
        if (tx_flush) begin
            tx_wp_d  = '0;
            tx_rp_d  = '0;
            tx_cnt_d = '0;
        end

        rx_wp_d  = rx_push ? rx_wp_q + RX_PTR_ONE : rx_wp_q;
        rx_rp_d  = rx_pop  ? rx_rp_q + RX_PTR_ONE : rx_rp_q;
        rx_cnt_d = rx_cnt_q;
        if (rx_push && !rx_pop) rx_cnt_d = rx_cnt_q + RX_CNT_ONE;
        if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - RX_CNT_ONE;
        if (rx_flush) begin
            rx_wp_d  = '0;
            rx_rp_d  = '0;
            rx_cnt_d = '0;
        end

        uart_we_d   = tx_pop;
        uart_char_d = tx_pop ? tx_mem_q[tx_rp_q] : uart_char_q;
        last_tx_d   = tx_push ? dma_io_wdata[7:0] : last_tx_q;
        term_d      = wr_term ? dma_io_wdata[15:0] : term_q;

        // a same-cycle set beats the clear
        tx_ovr_d = (tx_ovr_q && !ctrl_clr) || tx_ovr_set;
        rx_ovr_d = (rx_ovr_q && !ctrl_clr) || rx_ovr_set;
    end

    // read decode: snapshot the selected register on the strobe cycle
    always_comb begin
        rd_hit_d  = 1'b0;
        rd_data_d = 32'd0;
        if (dma_io_radr_en) begin
            case (dma_io_radr)
                A_TXDATA: begin rd_hit_d = 1'b1; rd_data_d = {24'd0, last_tx_q}; end
                A_STATUS: begin rd_hit_d = 1'b1; rd_data_d = status_w; end
                A_TERM:   begin rd_hit_d = 1'b1; rd_data_d = {16'd0, term_q}; end
                A_RXDATA: begin
                    rd_hit_d  = 1'b1;
                    rd_data_d = rx_empty ? 32'd0 : {23'd0, 1'b1, rx_mem_q[rx_rp_q]};
                end
                A_CTRL:   begin rd_hit_d = 1'b1; rd_data_d = 32'd0; end
                default:  begin rd_hit_d = 1'b0; rd_data_d = 32'd0; end
            endcase
        end
    end

    // state registers with synchronous reset; reset drops all queued bytes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_wp_q     <= '0;
            tx_rp_q     <= '0;
            tx_cnt_q    <= '0;
            rx_wp_q     <= '0;
            rx_rp_q     <= '0;
            rx_cnt_q    <= '0;
            tx_ovr_q    <= 1'b0;
            rx_ovr_q    <= 1'b0;
            uart_we_q   <= 1'b0;
            uart_char_q <= 8'd0;
            last_tx_q   <= 8'd0;
            term_q      <= TERM_RESET;
            rd_hit_q    <= 1'b0;
            rd_data_q   <= 32'd0;
        end else begin
            tx_wp_q     <= tx_wp_d;
            tx_rp_q     <= tx_rp_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_wp_q     <= rx_wp_d;
            rx_rp_q     <= rx_rp_d;
            rx_cnt_q    <= rx_cnt_d;
            tx_ovr_q    <= tx_ovr_d;
            rx_ovr_q    <= rx_ovr_d;
            uart_we_q   <= uart_we_d;
            uart_char_q <= uart_char_d;
            last_tx_q   <= last_tx_d;
            term_q      <= term_d;
            rd_hit_q    <= rd_hit_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wp_q] <= dma_io_wdata[7:0];
        if (rx_push) rx_mem_q[rx_wp_q] <= rout;
    end

    assign dma_io_rdata = rd_hit_q ? rd_data_q : dma_io_rdata_in;
    assign uart_io_we   = uart_we_q;
    assign uart_io_char = uart_char_q;
    assign uart_term    = term_q;

endmodule

// File: tb/tb_io_uart_fifo.sv
// Bench for io_uart_fifo: directed vector table, hand sequences for the FIFO
// corner cases, then random traffic against a queue-based reference model.
module tb_io_uart_fifo;

    localparam logic [13:0] BASE = 14'h3F00;
    localparam int          TXD  = 16;
    localparam int          RXD  = 16;

    logic        clk = 1'b0;
    logic        rst_n, we, radr_en, full, run, rout_en;
    logic [13:0] wadr, radr;
    logic [31:0] wdata, rdata_in, dma_io_rdata;
    logic [7:0]  rout, uart_io_char;
    logic        uart_io_we;
    logic [15:0] uart_term;

    int checks = 0;
    int errors = 0;

    io_uart_fifo #(.TX_DEPTH_LOG2(4), .RX_DEPTH_LOG2(4), .BASE_ADR(BASE), .TERM_RESET(16'd109)) dut (
        .clk(clk), .rst_n(rst_n),
        .dma_io_we(we), .dma_io_wadr(wadr), .dma_io_wdata(wdata),
        .dma_io_radr_en(radr_en), .dma_io_radr(radr),
        .dma_io_rdata_in(rdata_in), .dma_io_rdata(dma_io_rdata),
        .uart_io_char(uart_io_char), .uart_io_we(uart_io_we), .uart_io_full(full),
        .uart_term(uart_term), .cpu_run_state(run), .rout_en(rout_en), .rout(rout)
    );

    always #5 clk = ~clk;

    // reference model: FIFOs as queues, registers as plain variables
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    logic        m_tx_ovr, m_rx_ovr, m_we, m_hit;
    logic [7:0]  m_char, m_last;
    logic [15:0] m_term;
    logic [31:0] m_val;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_update();
        logic [13:0] wo, ro;
        logic        hit, prev_we, tx_was_full, rx_was_full, pop, tx_set, rx_set;
        logic        clr, ftx, frx;
        logic [31:0] val;
        if (!rst_n) begin
            tx_q.delete(); rx_q.delete();
            m_tx_ovr = 0; m_rx_ovr = 0; m_we = 0; m_char = 0; m_last = 0;
            m_term = 16'd109; m_hit = 0; m_val = 0;
            return;
        end
        wo = wadr - BASE;
        ro = radr - BASE;
        hit = 0; val = 0;
        if (radr_en) begin
            case (ro)
                14'd0: begin hit = 1; val = {24'd0, m_last}; end
                14'd1: begin
                    hit = 1;
                    val = {8'd0, 8'(rx_q.size()), 8'(tx_q.size()), 2'b00, m_rx_ovr, m_tx_ovr,
                           rx_q.size() == 0, rx_q.size() == RXD, tx_q.size() == 0, tx_q.size() == TXD};
                end
                14'd2: begin hit = 1; val = {16'd0, m_term}; end
                14'd3: begin hit = 1; val = (rx_q.size() > 0) ? {23'd0, 1'b1, rx_q[0]} : 32'd0; end
                14'd4: begin hit = 1; val = 0; end
                default: hit = 0;
            endcase
        end
        clr = we && wo == 14'd4 && wdata[0];
        ftx = we && wo == 14'd4 && wdata[1];
        frx = we && wo == 14'd4 && wdata[2];
        tx_was_full = (tx_q.size() == TXD);
        rx_was_full = (rx_q.size() == RXD);
        tx_set = 0; rx_set = 0;
        prev_we = m_we;
        m_we = 0;
        if (ftx) tx_q.delete();
        else begin
            if (tx_q.size() > 0 && !full && !prev_we) begin
                m_we = 1;
                m_char = tx_q.pop_front();
            end
            if (we && wo == 14'd0) begin
                if (tx_was_full) tx_set = 1;
                else begin tx_q.push_back(wdata[7:0]); m_last = wdata[7:0]; end
            end
        end
        pop = radr_en && ro == 14'd3 && rx_q.size() > 0;
        if (frx) rx_q.delete();
        else begin
            if (pop) void'(rx_q.pop_front());
            if (run && rout_en) begin
                if (rx_was_full && !pop) rx_set = 1;
                else rx_q.push_back(rout);
            end
        end
        if (we && wo == 14'd2) m_term = wdata[15:0];
        if (clr) begin m_tx_ovr = 0; m_rx_ovr = 0; end
        if (tx_set) m_tx_ovr = 1;
        if (rx_set) m_rx_ovr = 1;
        m_hit = hit;
        m_val = val;
    endtask

    // one clock: model follows the edge, outputs checked 1 time unit later
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk("uart_we", {31'd0, uart_io_we}, {31'd0, m_we});
        chk("uart_char", {24'd0, uart_io_char}, {24'd0, m_char});
        chk("uart_term", {16'd0, uart_term}, {16'd0, m_term});
        chk("rdata", dma_io_rdata, m_hit ? m_val : rdata_in);
    endtask

    task automatic idle();
        we = 0; radr_en = 0; rout_en = 0;
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] d);
        we = 1; wadr = BASE + 14'(off); wdata = d;
        step();
        we = 0;
    endtask

    task automatic rd(input logic [2:0] off, output logic [31:0] d);
        radr_en = 1; radr = BASE + 14'(off);
        step();
        radr_en = 0;
        d = dma_io_rdata;
    endtask

    task automatic rx_in(input logic [7:0] b);
        rout_en = 1; rout = b;
        step();
        rout_en = 0;
    endtask

    typedef struct {
        logic        rst_n;
        logic        we;
        logic [2:0]  woff;
        logic [31:0] wdata;
        logic        ren;
        logic [2:0]  roff;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_we;
        logic [7:0]  exp_char;
    } vec_t;

    vec_t tbl[13];

    initial begin
        logic [31:0] d;
        int pulses;

        // rst we woff wdata ren roff chk exp_rd exp_we exp_char
        tbl[0]  = '{1'b0, 1'b0, 3'd0, 32'd0,  1'b0, 3'd0, 1'b1, 32'hDEAD_BEEF, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 1'b0, 3'd0, 32'd0,  1'b1, 3'd1, 1'b1, 32'h0000_000A, 1'b0, 8'h00};
        tbl[2]  = '{1'b1, 1'b0, 3'd0, 32'd0,  1'b1, 3'd2, 1'b1, 32'd109,       1'b0, 8'h00};
        tbl[3]  = '{1'b1, 1'b1, 3'd2, 32'd54, 1'b0, 3'd0, 1'b1, 32'hDEAD_BEEF, 1'b0, 8'h00};
        tbl[4]  = '{1'b1, 1'b0, 3'd0, 32'd0,  1'b1, 3'd2, 1'b1, 32'd54,        1'b0, 8'h00};
        tbl[5]  = '{1'b1, 1'b1, 3'd0, 32'h41, 1'b0, 3'd0, 1'b0, 32'd0,         1'b0, 8'h00};
        tbl[6]  = '{1'b1, 1'b1, 3'd0, 32'h42, 1'b0, 3'd0, 1'b0, 32'd0,         1'b1, 8'h41};
        tbl[7]  = '{1'b1, 1'b1, 3'd0, 32'h43, 1'b0, 3'd0, 1'b0, 32'd0,         1'b0, 8'h00};
        tbl[8]  = '{1'b1, 1'b0, 3'd0, 32'd0,  1'b0, 3'd0, 1'b0, 32'd0,         1'b1, 8'h42};
        tbl[9]  = '{1'b1, 1'b0, 3'd0, 32'd0,  1'b0, 3'd0, 1'b0, 32'd0,         1'b0, 8'h00};
        tbl[10] = '{1'b1, 1'b0, 3'd0, 32'd0,  1'b1, 3'd0, 1'b1, 32'h43,        1'b1, 8'h43};
        tbl[11] = '{1'b1, 1'b0, 3'd0, 32'd0,  1'b1, 3'd5, 1'b1, 32'hDEAD_BEEF, 1'b0, 8'h00};
        tbl[12] = '{1'b1, 1'b0, 3'd0, 32'd0,  1'b1, 3'd4, 1'b1, 32'd0,         1'b0, 8'h00};

        rst_n = 0; we = 0; radr_en = 0; full = 0; run = 1; rout_en = 0;
        wadr = BASE; radr = BASE; wdata = 0; rout = 0; rdata_in = 32'hDEAD_BEEF;
        step();

        // directed table: reset, TERM, three-byte TX drain, read decode
        for (int i = 0; i < 13; i++) begin
            rst_n = tbl[i].rst_n;
            we = tbl[i].we; wadr = BASE + 14'(tbl[i].woff); wdata = tbl[i].wdata;
            radr_en = tbl[i].ren; radr = BASE + 14'(tbl[i].roff);
            step();
            if (tbl[i].chk_rd) chk("tbl_rdata", dma_io_rdata, tbl[i].exp_rd);
            chk("tbl_we", {31'd0, uart_io_we}, {31'd0, tbl[i].exp_we});
            if (tbl[i].exp_we) chk("tbl_char", {24'd0, uart_io_char}, {24'd0, tbl[i].exp_char});
        end
        idle();
        chk("term_port", {16'd0, uart_term}, 32'd54);

        // TX overflow while the core is full, then release and drain
        full = 1;
        for (int i = 0; i < 17; i++) wr(3'd0, 32'h10 + i);
        rd(3'd1, d); chk("tx_full_status", d, 32'h0000_1019);
        full = 0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (uart_io_we) pulses++;
        end
        chk("tx_drain_pulses", pulses, 32'd16);
        wr(3'd4, 32'h1);
        rd(3'd1, d); chk("tx_ovr_clear", d, 32'h0000_000A);

        // RX capture and pop, gated by cpu_run_state
        rx_in(8'h55); rx_in(8'h66);
        rd(3'd3, d); chk("rx_pop1", d, 32'h155);
        rd(3'd3, d); chk("rx_pop2", d, 32'h166);
        rd(3'd3, d); chk("rx_pop_empty", d, 32'h000);
        run = 0; rx_in(8'h77); run = 1;
        rd(3'd3, d); chk("rx_not_running", d, 32'h000);

        // RX full: same-cycle push and pop, then overflow, clear, flush
        for (int i = 0; i < 16; i++) rx_in(8'h80 + 8'(i));
        rd(3'd1, d); chk("rx_full_status", d, 32'h0010_0006);
        rout_en = 1; rout = 8'hAA; radr_en = 1; radr = BASE + 14'd3;
        step();
        idle();
        chk("rx_pushpop_data", dma_io_rdata, 32'h180);
        rd(3'd1, d); chk("rx_pushpop_status", d, 32'h0010_0006);
        rx_in(8'hBB);
        rd(3'd1, d); chk("rx_ovr_set", d, 32'h0010_0026);
        wr(3'd4, 32'h1);
        rd(3'd1, d); chk("rx_ovr_clear", d, 32'h0010_0006);
        wr(3'd4, 32'h4);
        rd(3'd1, d); chk("rx_flush", d, 32'h0000_000A);

        // TX flush, then reset in the middle of a drain
        full = 1;
        for (int i = 0; i < 5; i++) wr(3'd0, 32'h20 + i);
        wr(3'd4, 32'h2);
        rd(3'd1, d); chk("tx_flush", d, 32'h0000_000A);
        full = 0;
        wr(3'd0, 32'h31); wr(3'd0, 32'h32); wr(3'd0, 32'h33);
        step();
        rst_n = 0;
        step();
        chk("reset_mid_drain_we", {31'd0, uart_io_we}, 32'd0);
        rst_n = 1;
        rd(3'd1, d); chk("reset_mid_drain_status", d, 32'h0000_000A);
        for (int i = 0; i < 4; i++) step();

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] wo;
            rst_n = ($urandom_range(0, 299) != 0);
            we = ($urandom_range(0, 2) == 0);
            wo = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 5));
            if (wo == 3'd4 && $urandom_range(0, 3) != 0) wo = 3'd0;
            wadr = BASE + 14'(wo);
            wdata = $urandom;
            radr_en = ($urandom_range(0, 1) == 0);
            radr = BASE + 14'($urandom_range(0, 5));
            full = ($urandom_range(0, 3) == 0);
            run = ($urandom_range(0, 7) != 0);
            rout_en = ($urandom_range(0, 2) == 0);
            rout = 8'($urandom);
            rdata_in = $urandom;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
